// File: rtl/core_step_pkg.sv
// Shared types and widths for the core run/step sequencer.
package core_step_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } step_state_e;

  localparam int CNT_W = 16;
  localparam int PC_W  = 32;
  localparam int CYC_W = 32;

endpackage

// File: rtl/core_step_ctrl_debounce.sv
// Step-button conditioning: 2-FF synchroniser, stability counter and
// rising-edge pulse generator. The level only changes after
// DEBOUNCE_CYCLES consecutive synchronised samples disagree with it.
module step_debounce
  import core_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic pulse
);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  // Bring the raw asynchronous button into the clock domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= btn_in;
      r_s2 <= r_s1;
    end
  end

  // Accept a level change once it has been stable long enough; pulse on 0->1 only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_s2;
        r_cnt   <= '0;
        r_pulse <= r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign pulse = r_pulse;

endmodule

// File: rtl/core_step_ctrl.sv
// Run/step sequencer producing the core's global advance enable.
// Optional PC breakpoint logic is built when CORE_STEP_BP_EN is defined;
// without it the breakpoint ports are accepted but ignored.
module core_step_ctrl
  import core_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_CYCLES     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             debug_en,
  input  logic             debug_step,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  PC_IF,
  output logic             cpu_en,
  output logic             halted,
  output logic             bp_halt,
  output logic             step_pulse,
  output logic [CYC_W-1:0] cycle_cnt
);

  step_state_e      r_state;
  step_state_e      w_stateNext;
  logic [CNT_W-1:0] r_stepCnt;
  logic [CNT_W-1:0] w_stepCntNext;
  logic [CYC_W-1:0] r_cycleCnt;
  logic             w_bpHit;
  logic             w_setSkip;
  logic             w_setBpHalt;
  logic             w_clrBpHalt;
  logic             w_btnLevel;
  logic             w_unused;

  step_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn_in(debug_step),
    .level (w_btnLevel),
    .pulse (step_pulse)
  );

`ifdef CORE_STEP_BP_EN
  logic r_skip;
  logic r_bpHalt;

  // skip masks the breakpoint until the core has advanced at least once
  assign w_bpHit = bp_en & (PC_IF == bp_addr) & ~r_skip;
  assign bp_halt = r_bpHalt;
  assign w_unused = &{1'b0, w_btnLevel};

  // Breakpoint bookkeeping: skip after a resume, sticky halt cause
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skip   <= 1'b0;
      r_bpHalt <= 1'b0;
    end else begin
      if (cpu_en) begin
        r_skip <= 1'b0;
      end else if (w_setSkip) begin
        r_skip <= 1'b1;
      end
      if (w_setBpHalt) begin
        r_bpHalt <= 1'b1;
      end else if (w_clrBpHalt) begin
        r_bpHalt <= 1'b0;
      end
    end
  end
`else
  assign w_bpHit = 1'b0;
  assign bp_halt = 1'b0;
  assign w_unused = &{1'b0, w_btnLevel, bp_en, bp_addr, PC_IF,
                      w_setSkip, w_setBpHalt, w_clrBpHalt};
`endif

  // Enable is forced low during reset so the core cannot advance while held
  assign cpu_en = rst & ~w_bpHit &
                  (((r_state == RUN) & ~debug_en) | (r_state == STEP));
  assign halted    = (r_state == HALT);
  assign cycle_cnt = r_cycleCnt;

  // State and step-count registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RUN;
      r_stepCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_stepCnt <= w_stepCntNext;
    end
  end

  // Next-state logic; a press in HALT wins over the switch-release exit
  always_comb begin
    w_stateNext   = r_state;
    w_stepCntNext = r_stepCnt;
    w_setSkip     = 1'b0;
    w_setBpHalt   = 1'b0;
    w_clrBpHalt   = 1'b0;
    case (r_state)
      RUN: begin
        if (debug_en) begin
          w_stateNext = HALT;
        end else if (w_bpHit) begin
          w_stateNext = HALT;
          w_setBpHalt = 1'b1;
        end
      end
      HALT: begin
        if (step_pulse && debug_en) begin
          w_stateNext   = STEP;
          w_stepCntNext = CNT_W'(STEP_CYCLES - 1);
          w_setSkip     = 1'b1;
          w_clrBpHalt   = 1'b1;
        end else if (step_pulse) begin
          w_stateNext = RUN;
          w_setSkip   = 1'b1;
          w_clrBpHalt = 1'b1;
        end else if (!debug_en && !bp_halt) begin
          w_stateNext = RUN;
        end
      end
      STEP: begin
        if (w_bpHit) begin
          w_stateNext = HALT;
          w_setBpHalt = 1'b1;
        end else if (r_stepCnt == '0) begin
          w_stateNext = HALT;
        end else begin
          w_stepCntNext = r_stepCnt - 1'b1;
        end
      end
      default: begin
        w_stateNext = RUN;
      end
    endcase
  end

  // Count every cycle in which the core was allowed to advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycleCnt <= '0;
    end else if (cpu_en) begin
      r_cycleCnt <= r_cycleCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_core_step_ctrl.sv
// Directed bench for core_step_ctrl. Instance A: debounce 16, one cycle
// per step. Instance B: debounce 2, eight cycles per step, so a second
// press can be landed inside a running step.
module tb_core_step_ctrl;

  logic        clk;
  logic        rst;
  logic        debugEnA, stepA, debugEnB, stepB;
  logic        bpEn, bpEnB;
  logic [31:0] bpAddr;
  logic [31:0] pcIf;
  logic        cpuEnA, haltedA, bpHaltA, pulseA;
  logic        cpuEnB, haltedB, bpHaltB, pulseB;
  logic [31:0] cycA, cycB;
  logic [31:0] cycStart;

  int totalChecks = 0;
  int badChecks   = 0;
  int enA = 0, pulsesA = 0, enB = 0, pulsesB = 0;

  core_step_ctrl #(.DEBOUNCE_CYCLES(16), .STEP_CYCLES(1)) dutA (
    .clk(clk), .rst(rst), .debug_en(debugEnA), .debug_step(stepA),
    .bp_en(bpEn), .bp_addr(bpAddr), .PC_IF(pcIf),
    .cpu_en(cpuEnA), .halted(haltedA), .bp_halt(bpHaltA),
    .step_pulse(pulseA), .cycle_cnt(cycA)
  );

  core_step_ctrl #(.DEBOUNCE_CYCLES(2), .STEP_CYCLES(8)) dutB (
    .clk(clk), .rst(rst), .debug_en(debugEnB), .debug_step(stepB),
    .bp_en(bpEnB), .bp_addr(bpAddr), .PC_IF(pcIf),
    .cpu_en(cpuEnB), .halted(haltedB), .bp_halt(bpHaltB),
    .step_pulse(pulseB), .cycle_cnt(cycB)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal core model: fetch PC advances by 4 on every enabled cycle of A
  always @(posedge clk or negedge rst) begin
    if (!rst) pcIf <= 32'h0;
    else if (cpuEnA) pcIf <= pcIf + 32'd4;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance n cycles, sampling on the falling edge and tallying enables/pulses
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cpuEnA) enA++;
      if (pulseA) pulsesA++;
      if (cpuEnB) enB++;
      if (pulseB) pulsesB++;
    end
  endtask

  task automatic clearCounts();
    enA = 0; pulsesA = 0; enB = 0; pulsesB = 0;
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; debugEnA = 1'b0; stepA = 1'b0; debugEnB = 1'b0; stepB = 1'b0;
    bpEn = 1'b0; bpEnB = 1'b0; bpAddr = 32'h10;

    // Free run from reset
    applyStimulus(5);
    checkOutput("rst cpu_en A", 32'(cpuEnA), 32'd0);
    checkOutput("rst cpu_en B", 32'(cpuEnB), 32'd0);
    checkOutput("rst halted", 32'(haltedA), 32'd0);
    checkOutput("rst bp_halt", 32'(bpHaltA), 32'd0);
    checkOutput("rst step_pulse", 32'(pulseA), 32'd0);
    checkOutput("rst cycle_cnt", cycA, 32'd0);
    rst = 1'b1;
    applyStimulus(10);
    checkOutput("run cycle_cnt A", cycA, 32'd10);
    checkOutput("run cycle_cnt B", cycB, 32'd10);
    checkOutput("run cpu_en", 32'(cpuEnA), 32'd1);
    checkOutput("run halted", 32'(haltedA), 32'd0);

    // Step mode from reset: parks in HALT without advancing
    rst = 1'b0; debugEnA = 1'b1; debugEnB = 1'b1;
    applyStimulus(2);
    rst = 1'b1;
    applyStimulus(2);
    checkOutput("dbg halted", 32'(haltedA), 32'd1);
    checkOutput("dbg cpu_en", 32'(cpuEnA), 32'd0);
    checkOutput("dbg cycle_cnt", cycA, 32'd0);

    // Single clean press: one pulse, one enabled cycle
    clearCounts();
    cycStart = cycA;
    stepA = 1'b1;
    applyStimulus(40);
    stepA = 1'b0;
    applyStimulus(40);
    checkOutput("step pulses", 32'(pulsesA), 32'd1);
    checkOutput("step enables", 32'(enA), 32'd1);
    checkOutput("step cycle delta", cycA - cycStart, 32'd1);
    checkOutput("step halted", 32'(haltedA), 32'd1);

    // Bouncing button, toggling every 3 cycles, is rejected
    clearCounts();
    for (int i = 0; i < 20; i++) begin
      stepA = ~stepA;
      applyStimulus(3);
    end
    stepA = 1'b0;
    applyStimulus(20);
    checkOutput("bounce pulses", 32'(pulsesA), 32'd0);
    checkOutput("bounce enables", 32'(enA), 32'd0);
    checkOutput("bounce cycle_cnt", cycA, cycStart + 32'd1);

    // Second accepted press during an 8-cycle step is dropped
    clearCounts();
    stepB = 1'b1;
    applyStimulus(4);
    stepB = 1'b0;
    applyStimulus(2);
    stepB = 1'b1;
    applyStimulus(30);
    checkOutput("drop pulses", 32'(pulsesB), 32'd2);
    checkOutput("drop enables", 32'(enB), 32'd8);
    checkOutput("drop halted", 32'(haltedB), 32'd1);
    checkOutput("drop cycle_cnt", cycB, 32'd8);
    stepB = 1'b0;
    applyStimulus(10);
    checkOutput("release no pulse", 32'(pulsesB), 32'd2);

    // Asynchronous reset in the middle of a step
    clearCounts();
    stepB = 1'b1;
    for (int i = 0; i < 40 && enB < 2; i++) applyStimulus(1);
    checkOutput("midstep reached", 32'(enB), 32'd2);
    #1 rst = 1'b0;
    #1;
    checkOutput("midstep cpu_en", 32'(cpuEnB), 32'd0);
    checkOutput("midstep cycle_cnt", cycB, 32'd0);
    stepB = 1'b0; debugEnB = 1'b0; debugEnA = 1'b0;
    applyStimulus(2);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("post rst halted", 32'(haltedB), 32'd0);
    checkOutput("post rst cpu_en", 32'(cpuEnB), 32'd1);
    checkOutput("post rst cycle_cnt", cycB, 32'd1);

    // Breakpoint at PC 0x10
    rst = 1'b0; bpEn = 1'b1;
    applyStimulus(2);
    rst = 1'b1;
`ifdef CORE_STEP_BP_EN
    for (int i = 0; i < 20 && !haltedA; i++) applyStimulus(1);
    checkOutput("bp halted", 32'(haltedA), 32'd1);
    checkOutput("bp cpu_en", 32'(cpuEnA), 32'd0);
    checkOutput("bp pc", pcIf, 32'h10);
    checkOutput("bp sticky", 32'(bpHaltA), 32'd1);
    checkOutput("bp cycle_cnt", cycA, 32'd4);
    applyStimulus(5);
    checkOutput("bp frozen pc", pcIf, 32'h10);
    stepA = 1'b1;
    for (int i = 0; i < 40 && haltedA; i++) applyStimulus(1);
    checkOutput("resume halted", 32'(haltedA), 32'd0);
    checkOutput("resume bp_halt", 32'(bpHaltA), 32'd0);
    checkOutput("resume cpu_en", 32'(cpuEnA), 32'd1);
    checkOutput("resume pc", pcIf, 32'h10);
    applyStimulus(1);
    checkOutput("resume pc next", pcIf, 32'h14);
    stepA = 1'b0;
`else
    applyStimulus(10);
    checkOutput("nobp cpu_en", 32'(cpuEnA), 32'd1);
    checkOutput("nobp halted", 32'(haltedA), 32'd0);
    checkOutput("nobp bp_halt", 32'(bpHaltA), 32'd0);
    checkOutput("nobp pc", pcIf, 32'h28);
    checkOutput("nobp cycle_cnt", cycA, 32'd10);
`endif
    bpEn = 1'b0;

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
